// File: rtl/eth_tx_fcs_ins.sv
// Ethernet TX pad/FCS inserter: zero-pads short frames up to MIN_FRAME_BYTES and appends
// the IEEE 802.3 CRC-32, behind a single fully backpressured output register stage.
module eth_tx_fcs_ins #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tuser,
  output logic                         s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  input  logic                         m_axis_tready
);

  localparam logic [1:0]  ST_DATA  = 2'd0;
  localparam logic [1:0]  ST_PAD   = 2'd1;
  localparam logic [1:0]  ST_TAIL  = 2'd2;
  localparam logic [15:0] MinBytes = 16'(MIN_FRAME_BYTES);

  logic [1:0]  state_q, state_d;
  logic [15:0] byteCnt_q, byteCnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic [15:0] padRem_q, padRem_d;
  logic [23:0] tailFcs_q, tailFcs_d;
  logic [1:0]  tailRem_q, tailRem_d;
  logic [63:0] mData_q, mData_d;
  logic [7:0]  mKeep_q, mKeep_d;
  logic        mValid_q, mValid_d;
  logic        mLast_q, mLast_d;
  logic        mUser_q, mUser_d;

  logic        load, accept;
  logic [3:0]  nBytes, spaceLeft, k0;
  logic [16:0] sumFull;
  logic [15:0] lenTotal, padTotal;
  logic [63:0] keepLanes, beatData, fcsShifted;
  logic [7:0]  crcMask;
  logic [31:0] crcNext, fcsWord;
  logic        beatGo, emitFcs, frameDone, errNow;

  // Reflected CRC-32 (poly 0x04C11DB7) over the enabled byte lanes, lane 0 first.
  function automatic logic [31:0] crcUpdate(input logic [31:0] crcIn, input logic [63:0] data,
                                            input logic [7:0] mask);
    logic [31:0] c;
    c = crcIn;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] onesMask(input logic [3:0] k);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < k);
    return m;
  endfunction

  assign load          = !mValid_q || m_axis_tready;
  assign accept        = (state_q == ST_DATA) && load && s_axis_tvalid;
  assign s_axis_tready = (state_q == ST_DATA) && load;

  always_comb begin
    nBytes    = 4'd0;
    keepLanes = '0;
    for (int i = 0; i < 8; i++) begin
      nBytes = nBytes + {3'd0, s_axis_tkeep[i]};
      keepLanes[8*i +: 8] = {8{s_axis_tkeep[i]}};
    end
    sumFull   = {1'b0, byteCnt_q} + {13'd0, nBytes};
    lenTotal  = sumFull[16] ? 16'hFFFF : sumFull[15:0];
    padTotal  = (lenTotal < MinBytes) ? (MinBytes - lenTotal) : 16'd0;
    spaceLeft = 4'd8 - nBytes;
  end

  // Every produced beat is data/pad bytes in lanes 0..k0-1; FCS-bearing beats append the FCS at lane k0.
  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    crc_d     = crc_q;
    err_d     = err_q;
    padRem_d  = padRem_q;
    tailFcs_d = tailFcs_q;
    tailRem_d = tailRem_q;
    mData_d   = mData_q;
    mKeep_d   = mKeep_q;
    mValid_d  = mValid_q;
    mLast_d   = mLast_q;
    mUser_d   = mUser_q;
    beatGo    = 1'b0;
    emitFcs   = 1'b0;
    frameDone = 1'b0;
    k0        = 4'd0;
    beatData  = '0;
    crcMask   = '0;
    errNow    = err_q;

    if (load) begin
      mValid_d = 1'b0;
      mLast_d  = 1'b0;
      mUser_d  = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (accept) begin
          beatGo    = 1'b1;
          errNow    = err_q | s_axis_tuser;
          byteCnt_d = lenTotal;
          beatData  = s_axis_tdata & keepLanes;
          if (!s_axis_tlast) begin
            crcMask = s_axis_tkeep;
          end else if (padTotal >= {12'd0, spaceLeft}) begin
            crcMask  = 8'hFF;
            padRem_d = padTotal - {12'd0, spaceLeft};
            state_d  = ST_PAD;
          end else begin
            emitFcs = 1'b1;
            k0      = nBytes + padTotal[3:0];
          end
        end
      end
      ST_PAD: begin
        if (load) begin
          beatGo = 1'b1;
          if (padRem_q >= 16'd8) begin
            crcMask  = 8'hFF;
            padRem_d = padRem_q - 16'd8;
          end else begin
            emitFcs = 1'b1;
            k0      = padRem_q[3:0];
          end
        end
      end
      ST_TAIL: begin
        if (load) begin
          mValid_d  = 1'b1;
          mData_d   = {40'd0, tailFcs_q};
          mKeep_d   = onesMask({2'b00, tailRem_q});
          mLast_d   = 1'b1;
          mUser_d   = err_q;
          frameDone = 1'b1;
          state_d   = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase

    if (emitFcs) crcMask = onesMask(k0);
    crcNext    = crcUpdate(crc_q, beatData, crcMask);
    fcsWord    = errNow ? crcNext : ~crcNext;
    fcsShifted = {32'd0, fcsWord} << {k0, 3'b000};

    if (beatGo) begin
      mValid_d = 1'b1;
      mData_d  = beatData;
      mKeep_d  = 8'hFF;
      mLast_d  = 1'b0;
      mUser_d  = 1'b0;
      crc_d    = crcNext;
      err_d    = errNow;
      if (emitFcs) begin
        mData_d = beatData | fcsShifted;
        if (k0 <= 4'd4) begin
          mKeep_d   = onesMask(k0 + 4'd4);
          mLast_d   = 1'b1;
          mUser_d   = errNow;
          frameDone = 1'b1;
          state_d   = ST_DATA;
        end else begin
          // FCS bytes that spilled past lane 7 go out on a short tail beat.
          tailRem_d = 2'(k0 - 4'd4);
          case (k0)
            4'd5:    tailFcs_d = {16'd0, fcsWord[31:24]};
            4'd6:    tailFcs_d = {8'd0, fcsWord[31:16]};
            default: tailFcs_d = fcsWord[31:8];
          endcase
          state_d = ST_TAIL;
        end
      end
    end

    if (frameDone) begin
      byteCnt_d = 16'd0;
      crc_d     = 32'hFFFFFFFF;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DATA;
      byteCnt_q <= 16'd0;
      crc_q     <= 32'hFFFFFFFF;
      err_q     <= 1'b0;
      padRem_q  <= 16'd0;
      tailFcs_q <= 24'd0;
      tailRem_q <= 2'd0;
      mData_q   <= 64'd0;
      mKeep_q   <= 8'd0;
      mValid_q  <= 1'b0;
      mLast_q   <= 1'b0;
      mUser_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      padRem_q  <= padRem_d;
      tailFcs_q <= tailFcs_d;
      tailRem_q <= tailRem_d;
      mData_q   <= mData_d;
      mKeep_q   <= mKeep_d;
      mValid_q  <= mValid_d;
      mLast_q   <= mLast_d;
      mUser_q   <= mUser_d;
    end
  end

  assign m_axis_tdata  = mData_q;
  assign m_axis_tkeep  = mKeep_q;
  assign m_axis_tvalid = mValid_q;
  assign m_axis_tlast  = mLast_q;
  assign m_axis_tuser  = mUser_q;

endmodule

// File: tb/tb_eth_tx_fcs_ins.sv
// Bench for eth_tx_fcs_ins: one instance without padding (MIN=0) and one padding to 60 bytes,
// checked against hand constants and a byte-stream CRC-32 model.
module tb_eth_tx_fcs_ins;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk, rst;
  logic [63:0] sData;
  logic [7:0]  sKeep;
  logic        sLast, sUser, sValid0, sValid60, sReady0, sReady60, mReady;
  logic [63:0] mData0, mData60;
  logic [7:0]  mKeep0, mKeep60;
  logic        mValid0, mValid60, mLast0, mLast60, mUser0, mUser60;

  int          assertCount = 0;
  int          failCount   = 0;
  bit          randReady   = 1'b0;
  byte unsigned frameBytes[$];
  beat_t       expQ[$];
  beat_t       q0[$];
  beat_t       q60[$];

  eth_tx_fcs_ins #(.AXIS_DATA_WIDTH(64), .MIN_FRAME_BYTES(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tvalid(sValid0),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser), .s_axis_tready(sReady0),
    .m_axis_tdata(mData0), .m_axis_tkeep(mKeep0), .m_axis_tvalid(mValid0),
    .m_axis_tlast(mLast0), .m_axis_tuser(mUser0), .m_axis_tready(mReady)
  );

  eth_tx_fcs_ins #(.AXIS_DATA_WIDTH(64), .MIN_FRAME_BYTES(60)) dut60 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tvalid(sValid60),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser), .s_axis_tready(sReady60),
    .m_axis_tdata(mData60), .m_axis_tkeep(mKeep60), .m_axis_tvalid(mValid60),
    .m_axis_tlast(mLast60), .m_axis_tuser(mUser60), .m_axis_tready(mReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    mReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collect transferred beats at the falling edge and verify outputs hold steady while stalled.
  initial begin
    beat_t prev0, prev60, cur;
    bit stall0, stall60;
    stall0 = 1'b0;
    stall60 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall0 = 1'b0;
        stall60 = 1'b0;
      end else begin
        cur = {mData0, mKeep0, mLast0, mUser0};
        if (stall0) begin
          assertCount++;
          if (!mValid0 || cur !== prev0) begin
            failCount++;
            $display("[TB] FAIL stall_hold0 got valid=%0b beat=%h want beat=%h", mValid0, cur, prev0);
          end
        end
        if (mValid0 && mReady) q0.push_back(cur);
        stall0 = mValid0 && !mReady;
        prev0 = cur;
        cur = {mData60, mKeep60, mLast60, mUser60};
        if (stall60) begin
          assertCount++;
          if (!mValid60 || cur !== prev60) begin
            failCount++;
            $display("[TB] FAIL stall_hold60 got valid=%0b beat=%h want beat=%h", mValid60, cur, prev60);
          end
        end
        if (mValid60 && mReady) q60.push_back(cur);
        stall60 = mValid60 && !mReady;
        prev60 = cur;
      end
    end
  end

  function automatic logic [63:0] laneMask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic beat_t maskBeat(input beat_t b);
    beat_t r;
    r = b;
    r.data = b.data & laneMask(b.keep);
    return r;
  endfunction

  task automatic makeFrame(input int len, input int seed);
    frameBytes = {};
    for (int i = 0; i < len; i++) frameBytes.push_back(8'(i * 13 + seed + 1));
  endtask

  // Golden model: pad to minLen, CRC-32 in its MSB-first form on bit-reflected input, emit FCS LSB byte first.
  task automatic modelFrame(input int minLen, input bit err);
    byte unsigned b[$];
    logic [31:0] c, fcs;
    logic [7:0] v;
    beat_t bt;
    b = frameBytes;
    while (b.size() < minLen) b.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < b.size(); i++) begin
      v = b[i];
      for (int j = 0; j < 8; j++) c = {c[30:0], 1'b0} ^ ((c[31] ^ v[j]) ? 32'h04C11DB7 : 32'h0);
    end
    for (int j = 0; j < 32; j++) fcs[j] = ~c[31-j];
    if (err) fcs = ~fcs;
    for (int j = 0; j < 4; j++) b.push_back(fcs[8*j +: 8]);
    for (int s = 0; s < b.size(); s += 8) begin
      bt = '0;
      for (int j = 0; j < 8; j++) begin
        if (s + j < b.size()) begin
          bt.data[8*j +: 8] = b[s+j];
          bt.keep[j] = 1'b1;
        end
      end
      bt.last = (s + 8 >= b.size());
      bt.user = bt.last & err;
      expQ.push_back(bt);
    end
  endtask

  task automatic driveBeat(input bit sel, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u);
    int guard;
    guard = 0;
    sData = d;
    sKeep = k;
    sLast = l;
    sUser = u;
    if (sel) sValid60 = 1'b1;
    else sValid0 = 1'b1;
    @(negedge clk);
    while (!(sel ? sReady60 : sReady0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL input_ready_timeout got ready=0 for %0d cycles want ready=1", guard);
    end
    @(posedge clk);
    #1;
    sValid0 = 1'b0;
    sValid60 = 1'b0;
  endtask

  task automatic sendFrame(input bit sel, input int userBeat);
    int nb, beats;
    logic [63:0] d;
    logic [7:0] k;
    nb = frameBytes.size();
    beats = (nb + 7) / 8;
    for (int b = 0; b < beats; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < nb) begin
          d[8*j +: 8] = frameBytes[b*8+j];
          k[j] = 1'b1;
        end
      end
      driveBeat(sel, d, k, b == beats - 1, b == userBeat);
    end
  endtask

  task automatic waitBeats(input bit sel, input int n);
    int guard;
    guard = 0;
    while ((sel ? q60.size() : q0.size()) < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic runFrame(input bit sel, input int minLen, input int userBeat, input bit err);
    expQ = {};
    modelFrame(minLen, err);
    if (sel) q60 = {};
    else q0 = {};
    sendFrame(sel, userBeat);
    waitBeats(sel, expQ.size());
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    assertCount++;
    if (mValid0 !== 1'b0 || mValid60 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_tvalid got %b/%b want 0/0", mValid0, mValid60);
    end
    assertCount++;
    if (mData0 !== 64'd0 || mKeep0 !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL reset_data got %h/%h want 0/0", mData0, mKeep0);
    end
    assertCount++;
    if (mLast0 !== 1'b0 || mUser0 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_last_user got %b/%b want 0/0", mLast0, mUser0);
    end
    assertCount++;
    if (sReady0 !== 1'b1 || sReady60 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_tready got %b/%b want 1/1", sReady0, sReady60);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_check_value();
    beat_t want[2];
    beat_t got;
    frameBytes = {};
    for (int i = 0; i < 9; i++) frameBytes.push_back(8'(8'h31 + i));
    q0 = {};
    sendFrame(1'b0, -1);
    waitBeats(1'b0, 2);
    repeat (3) @(negedge clk);
    want[0] = {64'h3837363534333231, 8'hFF, 1'b0, 1'b0};
    want[1] = {64'h000000CBF4392639, 8'h1F, 1'b1, 1'b0};
    assertCount++;
    if (q0.size() != 2) begin
      failCount++;
      $display("[TB] FAIL check_beats got %0d want 2", q0.size());
    end
    for (int i = 0; i < 2 && i < q0.size(); i++) begin
      got = maskBeat(q0[i]);
      assertCount++;
      if (got !== want[i]) begin
        failCount++;
        $display("[TB] FAIL check_value beat %0d got %h want %h", i, got, want[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fcs_fit();
    makeFrame(12, 32);
    runFrame(1'b0, 0, -1, 1'b0);
    assertCount++;
    if (q0.size() != 2) begin
      failCount++;
      $display("[TB] FAIL fit_beats got %0d want 2", q0.size());
    end
    for (int i = 0; i < q0.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (maskBeat(q0[i]) !== expQ[i]) begin
        failCount++;
        $display("[TB] FAIL fit_model beat %0d got %h want %h", i, maskBeat(q0[i]), expQ[i]);
      end
    end
    if (q0.size() == 2) begin
      assertCount++;
      if (q0[1].keep !== 8'hFF || q0[1].last !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL fit_last got keep=%h last=%b want keep=ff last=1", q0[1].keep, q0[1].last);
      end
    end
  endtask

  task automatic test_fcs_tail();
    makeFrame(14, 77);
    runFrame(1'b0, 0, -1, 1'b0);
    assertCount++;
    if (q0.size() != 3) begin
      failCount++;
      $display("[TB] FAIL tail_beats got %0d want 3", q0.size());
    end
    for (int i = 0; i < q0.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (maskBeat(q0[i]) !== expQ[i]) begin
        failCount++;
        $display("[TB] FAIL tail_model beat %0d got %h want %h", i, maskBeat(q0[i]), expQ[i]);
      end
    end
    if (q0.size() == 3) begin
      assertCount++;
      if (q0[1].keep !== 8'hFF || q0[1].last !== 1'b0 || q0[2].keep !== 8'h03 || q0[2].last !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL tail_shape got keep=%h/%h last=%b/%b want ff/03 0/1",
                 q0[1].keep, q0[2].keep, q0[1].last, q0[2].last);
      end
    end
  endtask

  task automatic test_pad_short();
    makeFrame(14, 5);
    runFrame(1'b1, 60, -1, 1'b0);
    assertCount++;
    if (q60.size() != 8) begin
      failCount++;
      $display("[TB] FAIL pad_beats got %0d want 8", q60.size());
    end
    for (int i = 0; i < q60.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (maskBeat(q60[i]) !== expQ[i]) begin
        failCount++;
        $display("[TB] FAIL pad_model beat %0d got %h want %h", i, maskBeat(q60[i]), expQ[i]);
      end
    end
    if (q60.size() == 8) begin
      for (int i = 2; i < 7; i++) begin
        assertCount++;
        if (q60[i].data !== 64'd0 || q60[i].keep !== 8'hFF || q60[i].last !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL pad_zero beat %0d got %h want data=0 keep=ff last=0", i, q60[i]);
        end
      end
      assertCount++;
      if (q60[7].data[31:0] !== 32'd0 || q60[7].keep !== 8'hFF || q60[7].last !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL pad_final got %h want low lanes 0 keep=ff last=1", q60[7]);
      end
    end
  endtask

  task automatic test_error_pad();
    makeFrame(58, 99);
    runFrame(1'b1, 60, 3, 1'b1);
    assertCount++;
    if (q60.size() != 8) begin
      failCount++;
      $display("[TB] FAIL err_beats got %0d want 8", q60.size());
    end
    for (int i = 0; i < q60.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (maskBeat(q60[i]) !== expQ[i]) begin
        failCount++;
        $display("[TB] FAIL err_model beat %0d got %h want %h", i, maskBeat(q60[i]), expQ[i]);
      end
    end
    if (q60.size() == 8) begin
      assertCount++;
      if (q60[7].data[31:16] !== 16'd0 || q60[7].keep !== 8'hFF || q60[7].user !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL err_final got %h want lanes2-3 zero keep=ff user=1", q60[7]);
      end
      assertCount++;
      if (q60[3].user !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL err_user_midframe got %b want 0", q60[3].user);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    randReady = 1'b1;
    expQ = {};
    q60 = {};
    fork
      begin
        int len, ub, beats;
        for (int f = 0; f < 200; f++) begin
          len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 80) : $urandom_range(1, 1600);
          beats = (len + 7) / 8;
          ub = ($urandom_range(0, 9) == 0) ? $urandom_range(0, beats - 1) : -1;
          makeFrame(len, f);
          modelFrame(60, ub >= 0);
          sendFrame(1'b1, ub);
        end
        done = 1'b1;
      end
      begin
        int idle;
        beat_t got, want;
        idle = 0;
        while (!(done && expQ.size() == 0) && idle < 3000) begin
          @(negedge clk);
          idle++;
          while (q60.size() > 0) begin
            got = maskBeat(q60.pop_front());
            idle = 0;
            assertCount++;
            if (expQ.size() == 0) begin
              failCount++;
              $display("[TB] FAIL b2b_extra got %h want no beat", got);
            end else begin
              want = expQ.pop_front();
              if (got !== want) begin
                failCount++;
                $display("[TB] FAIL b2b_model got %h want %h", got, want);
              end
            end
          end
        end
        assertCount++;
        if (expQ.size() != 0) begin
          failCount++;
          $display("[TB] FAIL b2b_missing got %0d beats outstanding want 0", expQ.size());
        end
      end
    join
    randReady = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    for (int b = 0; b < 3; b++) driveBeat(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    assertCount++;
    if (mValid60 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_tvalid got %b want 0", mValid60);
    end
    assertCount++;
    if (mData60 !== 64'd0 || mKeep60 !== 8'd0 || mLast60 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs got %h/%h/%b want 0/0/0", mData60, mKeep60, mLast60);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    makeFrame(14, 41);
    runFrame(1'b1, 60, -1, 1'b0);
    assertCount++;
    if (q60.size() != 8) begin
      failCount++;
      $display("[TB] FAIL restart_beats got %0d want 8", q60.size());
    end
    for (int i = 0; i < q60.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (maskBeat(q60[i]) !== expQ[i]) begin
        failCount++;
        $display("[TB] FAIL restart_model beat %0d got %h want %h", i, maskBeat(q60[i]), expQ[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sData = '0;
    sKeep = '0;
    sLast = 1'b0;
    sUser = 1'b0;
    sValid0 = 1'b0;
    sValid60 = 1'b0;
    test_reset();
    test_check_value();
    test_fcs_fit();
    test_fcs_tail();
    test_pad_short();
    test_error_pad();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
